issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  In-order circular issue queue between decode and the issue/dispatch stage.
//  - Accepts up to 4 decoded ISSUE_QUEUE_ELEMENTs per cycle from decode.
//  - Reports free space back to decode so decode can stall.
//  - Presents up to ISSUE_WIDTH oldest entries to dispatch each cycle.
//  - Flushes the whole queue on pipeline redirect.
// PARAMETERS
//  DEPTH        16  entry count; must be a power of two, >= 8
//  ISSUE_WIDTH  2   entries presented and popped per cycle (1..4)
// PORTS
//  clk                     in   1               rising-edge clock
//  rst_n                   in   1               async, active-low reset
//  issue_queue_element     in   4xISSUE_QUEUE_ELEMENT  decoded slots; valid slots packed low
//  issue_queue_push_number in   3               entries to write this cycle (0..4)
//  iq_size_left            out  3               free entries, saturated at 7
//  flush                   in   1               redirect: discard all entries
//  issue_ready_number      in   3               entries dispatch accepts this cycle (0..ISSUE_WIDTH)
//  issue_element           out  ISSUE_WIDTHxISSUE_QUEUE_ELEMENT  head entries, oldest at [0]
//  issue_valid             out  ISSUE_WIDTH     issue_element[i] holds a real entry
// BEHAVIOUR
//  Reset, async on rst_n low:
//  - head = tail = count = 0.
//  - iq_size_left = 7 (saturated); issue_valid = 0; issue_element = '0.
//  Storage, pointers and count:
//  - head/tail are log2(DEPTH) bits and wrap naturally.
//  - count is log2(DEPTH)+1 bits; free = DEPTH - count.
//  iq_size_left:
//  - = (free > 7) ? 7 : free, from registered count only. No same-cycle pop credit,
//    so there is no combinational loop with decode.
//  Push:
//  - Slots 0..push_number-1 are written at tail+i; tail += push_number at the edge.
//  - Pushed entries become visible on issue_element the next cycle (latency 1; no bypass).
//  - If push_number > free: protocol violation, whole push dropped (no partial write),
//    SVA assertion fires.
//  Pop:
//  - issue_valid[i] = (i < count); issue_element[i] = mem[head+i], combinational from storage.
//  - pop = min(issue_ready_number, count, ISSUE_WIDTH); head += pop.
//  - Invalid entries are never popped.
//  Simultaneous push and pop: both apply; count_next = count + push - pop.
//  - A push is checked against free at the start of the cycle, not after the pop.
//  flush:
//  - Highest priority: head = tail = count = 0 at the edge.
//  - Push and pop in the flush cycle are ignored.
//  - issue_valid is still driven from the pre-flush count during the flush cycle;
//    dispatch must gate on flush.
//  Reset mid-operation: immediate clear; no entry survives.
//  Empty: count = 0 -> issue_valid = 0; issue_ready_number is ignored.
//  Full: count = DEPTH -> iq_size_left = 0; decode stalls.
// CONFIGURATION
//  `IQ_OCCUPANCY_STATS_EN defined adds the following outputs:
//  - stat_full_cycles 32b: cycles with a push_number > free request.
//  - stat_peak_count log2(DEPTH)+1 b: maximum count seen.
//  - Both counters are cleared by rst_n only; flush does not clear them.
//  - stat_full_cycles saturates at all-ones.
//  Undefined: ports and logic absent. Functional behaviour is identical either way.
// STRUCTURE
//  - ISSUE_QUEUE_ELEMENT, bool, `true/`false live in the shared defines header.
//  - Add an IQ_PTR_T typedef derived from DEPTH there.
//  - One sub-module, iq_storage: DEPTH-entry RAM with 4 write ports and
//    ISSUE_WIDTH combinational read ports.
//  - Pointer, count and flush logic stay in issue_queue.
// TESTING
//  - Reset, then push 4,4,4,3 with no ready -> count 15; iq_size_left 1;
//    issue_element[0] = first pushed.
//  - Full queue (16), push 1 -> push dropped, assertion hit, count stays 16,
//    iq_size_left 0.
//  - Wrap-around: 12 pushes, pop 12, push 8 -> order preserved across
//    mem[15] -> mem[0]; tail = 4.
//  - Same cycle: count 3, push 4 + ready 2 -> count 5; popped = two oldest;
//    new entries visible next cycle only.
//  - flush with push 4 and ready 2 at count 9 -> count 0 next cycle,
//    issue_valid 0, iq_size_left 7.
//  - rst_n low mid-stream at count 10 -> outputs reset immediately (asynchronous).
//    With `IQ_OCCUPANCY_STATS_EN: peak reads 10 before the reset, 0 after.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared issue-queue types: element format, pointer type, helpers.
// Optional build macro used by the top: IQ_OCCUPANCY_STATS_EN.
`ifndef ISSUE_QUEUE_PKG_SV
`define ISSUE_QUEUE_PKG_SV
`define TRUE  1'b1
`define FALSE 1'b0

package issue_queue_pkg;

  localparam int IQ_DEPTH       = 16;
  localparam int IQ_ISSUE_WIDTH = 2;

  typedef logic bool;

  typedef logic [$clog2(IQ_DEPTH)-1:0] IQ_PTR_T;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
  } ISSUE_QUEUE_ELEMENT;

  function automatic logic [2:0] iq_sat7(
    input logic [7:0] v
  );
    return (v > 8'd7) ? 3'd7 : v[2:0];
  endfunction

endpackage

`endif

// File: rtl/issue_queue_iq_storage.sv
// Issue-queue entry RAM: 4 write ports, RD_PORTS async read ports.
// Write addresses within one cycle are always distinct (tail+0..3).
module iq_storage
    import issue_queue_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int RD_PORTS = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic [3:0]                        i_we,
    input  logic [3:0][AW-1:0]                i_waddr,
    input  ISSUE_QUEUE_ELEMENT [3:0]          i_wdata,
    input  logic [RD_PORTS-1:0][AW-1:0]       i_raddr,
    output ISSUE_QUEUE_ELEMENT [RD_PORTS-1:0] o_rdata
);

    ISSUE_QUEUE_ELEMENT r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int w = 0; w < 4; w++) begin
            if (i_we[w]) begin
                r_mem[i_waddr[w]] <= i_wdata[w];
            end
        end
    end

    for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
        assign o_rdata[r] = r_mem[i_raddr[r]];
    end

endmodule

// File: rtl/issue_queue.sv
// In-order circular issue queue between decode and dispatch.
// Define IQ_OCCUPANCY_STATS_EN to add occupancy statistics outputs.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH       = IQ_DEPTH,
    parameter int ISSUE_WIDTH = IQ_ISSUE_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  ISSUE_QUEUE_ELEMENT [3:0]             issue_queue_element,
    input  logic [2:0]                           issue_queue_push_number,
    output logic [2:0]                           iq_size_left,
    input  logic                                 flush,
    input  logic [2:0]                           issue_ready_number,
    output ISSUE_QUEUE_ELEMENT [ISSUE_WIDTH-1:0] issue_element,
    output logic [ISSUE_WIDTH-1:0]               issue_valid
`ifdef IQ_OCCUPANCY_STATS_EN
    ,
    output logic [31:0]                          stat_full_cycles,
    output logic [$clog2(DEPTH):0]               stat_peak_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop;
    logic [CW-1:0] w_count_next;
    bool           w_push_drop;

    logic [3:0]                       w_we;
    logic [3:0][AW-1:0]               w_waddr;
    logic [ISSUE_WIDTH-1:0][AW-1:0]   w_raddr;
    ISSUE_QUEUE_ELEMENT [ISSUE_WIDTH-1:0] w_rdata;

    // Push is judged against free space at cycle start, never after the pop.
    always_comb begin
        w_free      = CW'(DEPTH) - r_count;
        w_push_drop = (CW'(issue_queue_push_number) > w_free);
        w_push_n    = CW'(issue_queue_push_number);
        if (flush || w_push_drop) begin
            w_push_n = '0;
        end
        w_pop = CW'(issue_ready_number);
        if (w_pop > CW'(ISSUE_WIDTH)) begin
            w_pop = CW'(ISSUE_WIDTH);
        end
        if (w_pop > r_count) begin
            w_pop = r_count;
        end
        if (flush) begin
            w_pop = '0;
        end
        w_count_next = flush ? '0 : (r_count + w_push_n - w_pop);
    end

    assign iq_size_left = iq_sat7(8'(w_free));

    for (genvar i = 0; i < 4; i++) begin : g_wr
        assign w_we[i]    = (CW'(i) < w_push_n);
        assign w_waddr[i] = r_tail + AW'(i);
    end

    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_rd
        assign w_raddr[i]       = r_head + AW'(i);
        assign issue_valid[i]   = (CW'(i) < r_count);
        assign issue_element[i] = issue_valid[i] ? w_rdata[i] : '0;
    end

    iq_storage #(
        .DEPTH    (DEPTH),
        .RD_PORTS (ISSUE_WIDTH)
    ) u_storage (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (issue_queue_element),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_pop[AW-1:0];
            r_tail  <= r_tail + w_push_n[AW-1:0];
            r_count <= w_count_next;
        end
    end

`ifdef IQ_OCCUPANCY_STATS_EN
    logic [31:0]   r_full_cycles;
    logic [CW-1:0] r_peak_count;

    // Only rst_n clears the statistics; a redirect keeps history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full_cycles <= '0;
            r_peak_count  <= '0;
        end else begin
            if (w_push_drop && (r_full_cycles != '1)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
            if (w_count_next > r_peak_count) begin
                r_peak_count <= w_count_next;
            end
        end
    end

    assign stat_full_cycles = r_full_cycles;
    assign stat_peak_count  = r_peak_count;
`endif

    a_no_overflow_push : assert property (
        @(posedge clk) disable iff (!rst_n) !w_push_drop
    ) else $warning("issue_queue: push_number exceeds free entries, push dropped");

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: stimulus table plus queue-model scoreboard.
// Covers fill, overflow, wrap, push+pop, flush and async reset.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = 2;
    localparam int NV    = 39;

    typedef struct {
        int pn;
        int rn;
        bit fl;
        int left;
    } vec_t;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b1;
    ISSUE_QUEUE_ELEMENT [3:0]       issue_queue_element;
    logic [2:0]                     issue_queue_push_number;
    logic [2:0]                     iq_size_left;
    logic                           flush;
    logic [2:0]                     issue_ready_number;
    ISSUE_QUEUE_ELEMENT [IW-1:0]    issue_element;
    logic [IW-1:0]                  issue_valid;
`ifdef IQ_OCCUPANCY_STATS_EN
    logic [31:0]                    stat_full_cycles;
    logic [4:0]                     stat_peak_count;
`endif

    issue_queue #(
        .DEPTH       (DEPTH),
        .ISSUE_WIDTH (IW)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .issue_queue_element     (issue_queue_element),
        .issue_queue_push_number (issue_queue_push_number),
        .iq_size_left            (iq_size_left),
        .flush                   (flush),
        .issue_ready_number      (issue_ready_number),
        .issue_element           (issue_element),
        .issue_valid             (issue_valid)
`ifdef IQ_OCCUPANCY_STATS_EN
        ,
        .stat_full_cycles        (stat_full_cycles),
        .stat_peak_count         (stat_peak_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int seq   = 0;
    ISSUE_QUEUE_ELEMENT mq[$];
    vec_t vt [NV];

    function automatic ISSUE_QUEUE_ELEMENT mk(input int s);
        ISSUE_QUEUE_ELEMENT e;
        e.pc   = 32'h1000 + 32'(s) * 32'd4;
        e.inst = 32'(s) ^ 32'hDEAD_0000;
        e.rd   = 5'(s);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Drive at negedge, compare before the next posedge, then advance model.
    task automatic step(input int idx, input vec_t v);
        int free;
        int pop;
        bit ev;
        issue_queue_push_number = 3'(v.pn);
        issue_ready_number      = 3'(v.rn);
        flush                   = v.fl;
        for (int i = 0; i < 4; i++) begin
            issue_queue_element[i] = (i < v.pn) ? mk(seq + i) : '1;
        end
        #1;
        free = DEPTH - mq.size();
        chk($sformatf("r%0d left", idx), 80'(iq_size_left), 80'(v.left));
        chk($sformatf("r%0d drop", idx), 80'(dut.w_push_drop),
            80'(v.pn > free));
        for (int i = 0; i < IW; i++) begin
            ev = (i < mq.size());
            chk($sformatf("r%0d valid%0d", idx, i), 80'(issue_valid[i]),
                80'(ev));
            chk($sformatf("r%0d elem%0d", idx, i), 80'(issue_element[i]),
                ev ? 80'(mq[i]) : 80'd0);
        end
        if (v.fl) begin
            mq.delete();
        end else begin
            pop = v.rn;
            if (pop > IW) pop = IW;
            if (pop > mq.size()) pop = mq.size();
            repeat (pop) void'(mq.pop_front());
            if (v.pn <= free) begin
                for (int i = 0; i < v.pn; i++) mq.push_back(mk(seq + i));
            end
        end
        seq += v.pn;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) step(r, vt[r]);
    endtask

    initial begin
        vt = '{
            '{4,0,0,7}, '{4,0,0,7}, '{4,0,0,7}, '{3,0,0,4}, '{1,0,0,1},
            '{1,0,0,0}, '{0,3,0,0}, '{0,2,0,2}, '{0,2,0,4}, '{0,2,0,6},
            '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7},
            '{4,0,0,7}, '{4,0,0,7}, '{4,0,0,7}, '{0,2,0,4}, '{0,2,0,6},
            '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7}, '{4,0,0,7},
            '{4,0,0,7}, '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7}, '{0,2,0,7},
            '{3,0,0,7}, '{4,2,0,7}, '{0,0,0,7}, '{4,0,0,7}, '{4,2,1,7},
            '{0,0,0,7}, '{4,0,0,7}, '{4,0,0,7}, '{2,0,0,7}
        };
        issue_queue_element     = '0;
        issue_queue_push_number = '0;
        issue_ready_number      = '0;
        flush                   = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst left", 80'(iq_size_left), 80'd7);
        chk("rst valid", 80'(issue_valid), 80'd0);
        chk("rst elem", 80'(issue_element), 80'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(0, 25);
        chk("wrap tail", 80'(dut.r_tail), 80'd4);
        chk("wrap head", 80'(dut.r_head), 80'd12);
        run(26, 35);
`ifdef IQ_OCCUPANCY_STATS_EN
        chk("stat full", 80'(stat_full_cycles), 80'd1);
        chk("stat peak16", 80'(stat_peak_count), 80'd16);
`endif

        rst_n = 1'b0;
        #1;
`ifdef IQ_OCCUPANCY_STATS_EN
        chk("stat peak clr", 80'(stat_peak_count), 80'd0);
        chk("stat full clr", 80'(stat_full_cycles), 80'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();

        run(36, 38);
        issue_queue_push_number = '0;
        issue_ready_number      = '0;
        #1;
        chk("mid left", 80'(iq_size_left), 80'd6);
        chk("mid valid", 80'(issue_valid), 80'd3);
`ifdef IQ_OCCUPANCY_STATS_EN
        chk("mid peak", 80'(stat_peak_count), 80'd10);
`endif
        #1 rst_n = 1'b0;
        #1;
        chk("async left", 80'(iq_size_left), 80'd7);
        chk("async valid", 80'(issue_valid), 80'd0);
        chk("async elem", 80'(issue_element), 80'd0);
`ifdef IQ_OCCUPANCY_STATS_EN
        chk("async peak", 80'(stat_peak_count), 80'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        step(99, '{0, 2, 0, 7});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
